// File: rtl/softmax_in_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_in_packer_if
//  Description : Bundles the two handshakes around softmax_in_packer.
//                - Scalar score stream in: in_data / in_valid / in_last / in_ready
//                - Packed vector out:      x_in / x_in_valid / softmax_ready /
//                                          lane_count
//                slave  : the packer side (consumes scores, produces vectors)
//                master : the environment side (score source + softmax sink)
//  Revision    : 1.0 - initial release
// ============================================================================
interface softmax_in_packer_if #(
  parameter int N = 64,
  parameter int W = 16
);
  localparam int CNT_W = $clog2(N) + 1;

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [N*W-1:0]   x_in;
  logic             x_in_valid;
  logic             softmax_ready;
  logic [CNT_W-1:0] lane_count;

  modport slave (
    input  in_data, in_valid, in_last, softmax_ready,
    output in_ready, x_in, x_in_valid, lane_count
  );

  modport master (
    output in_data, in_valid, in_last, softmax_ready,
    input  in_ready, x_in, x_in_valid, lane_count
  );
endinterface
`default_nettype wire

// File: rtl/softmax_in_packer.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_in_packer
//  Description : Stream-to-vector front end for softmax. Collects one W-bit
//                score per accepted beat into an N-lane vector, element 0 in
//                the most significant lane. A row ends either on in_last or
//                after N elements; on in_last the remaining lanes are filled
//                with PAD_VALUE (FP16 -inf) so they contribute exp = 0.
//  Ports       : clk           - rising-edge clock
//                rst_n         - asynchronous active-low reset
//                bus.slave     - in_data/in_valid/in_last/in_ready score
//                                stream; x_in/x_in_valid/softmax_ready vector
//                                handshake; lane_count = real lanes (1..N)
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_in_packer #(
  parameter int             N         = 64,
  parameter int             W         = 16,
  parameter logic [W-1:0]   PAD_VALUE = 16'hFC00
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  softmax_in_packer_if.slave bus
);

  localparam int               IDX_W     = $clog2(N);
  localparam int               CNT_W     = IDX_W + 1;
  localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(N - 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_x_in_valid;
  logic [CNT_W-1:0] r_lane_count;

  logic             w_accept;
  logic             w_row_end;

  // in_ready is a registered copy of "state is FILL", so accept needs no
  // extra state decode.
  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_row_end = bus.in_last | (r_idx == c_idx_max);

  // --------------------------------------------------------------------------
  // Lane storage. Each lane decides independently whether the current accept
  // targets it (lane == idx) or, on a terminating in_last, lies beyond the
  // last real element and must take the pad value in the same edge.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam logic [IDX_W-1:0] c_lane = IDX_W'(j);

    logic [W-1:0] r_lane;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lane <= '0;
      end else if (w_accept) begin
        if (r_idx == c_lane) begin
          r_lane <= bus.in_data;
        end else if (bus.in_last && (c_lane > r_idx)) begin
          r_lane <= PAD_VALUE;
        end
      end
    end

    // Element 0 sits in the top lane, element N-1 in the bottom lane.
    assign bus.x_in[(N-j)*W-1 -: W] = r_lane;
  end

  // --------------------------------------------------------------------------
  // Control FSM. Lanes not yet rewritten during FILL keep stale data; that is
  // harmless because x_in_valid is low until the row is complete.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_idx        <= '0;
      r_in_ready   <= 1'b1;
      r_x_in_valid <= 1'b0;
      r_lane_count <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (w_row_end) begin
              r_state      <= S_OUT;
              r_idx        <= '0;
              r_lane_count <= {1'b0, r_idx} + CNT_W'(1);
              r_in_ready   <= 1'b0;
              r_x_in_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_OUT: begin
          // Vector and lane_count hold until softmax takes them.
          if (bus.softmax_ready) begin
            r_state      <= S_FILL;
            r_in_ready   <= 1'b1;
            r_x_in_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_FILL;
          r_in_ready   <= 1'b1;
          r_x_in_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.x_in_valid = r_x_in_valid;
  assign bus.lane_count = r_lane_count;

endmodule
`default_nettype wire

// File: tb/tb_softmax_in_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_in_packer
//  Description : Scoreboard bench for softmax_in_packer. The driver pushes the
//                expected vector for every completed row into a queue; an
//                independent negedge monitor pops and compares on each
//                vector handshake and checks handshake-level properties.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_in_packer;

  localparam int           N   = 64;
  localparam int           W   = 16;
  localparam logic [W-1:0] PAD = 16'hFC00;

  typedef struct {
    logic [N*W-1:0] vec;
    int             cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  softmax_in_packer_if #(.N(N), .W(W)) bus ();

  softmax_in_packer #(.N(N), .W(W), .PAD_VALUE(PAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int             total = 0;
  int             bad   = 0;
  exp_t           exp_q[$];
  logic [W-1:0]   row[$];
  int             rdy_mode = 0;   // 0: ready=1, 1: random, 2: ready=0
  bit             mon_en = 0;
  bit             exp_valid_next = 0;
  bit             prev_hold = 0;
  bit             prev_hs = 0;
  logic [N*W-1:0] prev_vec;
  logic [7:0]     prev_cnt;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endfunction

  function automatic void chk_vec(string nm, logic [N*W-1:0] act, logic [N*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      for (int k = 0; k < N; k++) begin
        if (act[(N-k)*W-1 -: W] !== req[(N-k)*W-1 -: W]) begin
          $display("FAIL %s: lane %0d got %h required %h", nm, k,
                   act[(N-k)*W-1 -: W], req[(N-k)*W-1 -: W]);
          break;
        end
      end
    end
  endfunction

  // Reference model: a row is a list of scores; it closes at N elements or
  // on last, and the vector is those scores MSB-first followed by pads.
  function automatic bit model_add(logic [W-1:0] d, logic last);
    exp_t e;
    row.push_back(d);
    if (row.size() == N || last) begin
      e.vec = '0;
      for (int k = 0; k < N; k++)
        e.vec[(N-k)*W-1 -: W] = (k < row.size()) ? row[k] : PAD;
      e.cnt = row.size();
      exp_q.push_back(e);
      row.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // softmax_ready generator
  initial begin
    bus.softmax_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.softmax_ready = 1'b1;
        1:       bus.softmax_ready = 1'($urandom_range(0, 1));
        default: bus.softmax_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (exp_valid_next) begin
        chk("latency_valid", bus.x_in_valid, 1);
        exp_valid_next = 0;
      end
      chk("ready_vs_valid", bus.in_ready, !bus.x_in_valid);
      if (prev_hs)
        chk("valid_drop_after_hs", bus.x_in_valid, 0);
      if (prev_hold && bus.x_in_valid) begin
        chk_vec("hold_x_in", bus.x_in, prev_vec);
        chk("hold_lane_count", bus.lane_count, prev_cnt);
      end
      if (bus.x_in_valid && bus.softmax_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vector: got lane_count %0d required none", bus.lane_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk_vec("vector", bus.x_in, e.vec);
          chk("lane_count", bus.lane_count, e.cnt);
        end
        prev_hs = 1;
      end else begin
        prev_hs = 0;
      end
      prev_hold = bus.x_in_valid && !bus.softmax_ready;
      prev_vec  = bus.x_in;
      prev_cnt  = bus.lane_count;
    end
  end

  // All tasks are entered and left at posedge + 1.
  task automatic send(input logic [W-1:0] d, input logic last, output int edges);
    logic acc;
    edges = 0;
    acc   = 1'b0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!acc && edges < 1000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      edges++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'($urandom);     // stray in_last without valid
    bus.in_data  = 16'($urandom);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 1000 cycles");
    end else if (model_add(d, last)) begin
      exp_valid_next = 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_vec("rst_x_in", bus.x_in, '0);
    chk("rst_x_in_valid", bus.x_in_valid, 0);
    chk("rst_lane_count", bus.lane_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    row.delete();
    exp_q.delete();
    exp_valid_next = 0;
    prev_hold = 0;
    prev_hs   = 0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_valid", bus.x_in_valid, 0);
    @(posedge clk);
    #1;
    mon_en = 1;
  endtask

  initial begin
    int e;
    int sum;
    int len;
    bit no_last;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Full 64-element row, sink always ready
    rdy_mode = 0;
    for (int k = 0; k < N; k++) send(16'h3C00 + 16'(k), k == N-1, e);
    drain();

    // Short row with padding
    send(16'h4000, 0, e);
    send(16'h4200, 0, e);
    send(16'h4400, 0, e);
    send(16'h4500, 0, e);
    send(16'h4600, 1, e);
    drain();

    // Backpressure: short row held ~20 cycles while the next row's element waits
    rdy_mode = 2;
    send(16'h4100, 0, e);
    send(16'h4300, 1, e);
    fork
      begin
        repeat (20) @(posedge clk);
        rdy_mode = 0;
      end
    join_none
    // Single-element row, offered during backpressure
    send(16'hBC00, 1, e);
    chk("bp_wait_edges_min", (e >= 18), 1);
    drain();

    // Back-to-back rows: one idle cycle between them
    sum = 0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) begin
        send(16'($urandom), k == N-1, e);
        sum += e;
      end
    chk("b2b_edges", sum, 2*N + 1);
    drain();

    // Reset mid-row discards the partial row
    for (int k = 0; k < 30; k++) send(16'h5000 + 16'(k), 0, e);
    do_reset();
    send(16'h3800, 0, e);
    send(16'h3A00, 0, e);
    send(16'h3C00, 1, e);
    drain();

    // Randomized rows, random gaps and random sink readiness
    rdy_mode = 1;
    for (int r = 0; r < 30; r++) begin
      len     = $urandom_range(1, N + 8);
      no_last = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        send(16'($urandom), (k == len-1) && !no_last, e);
      end
    end
    rdy_mode = 0;
    if (row.size() != 0) send(16'h1234, 1, e);
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/softmax_in_packer.md
Name: softmax_in_packer

Overview:
- Stream-to-vector front end for the `softmax` block.
- Accepts one FP16 score per cycle over a valid/ready stream and assembles N scores into one packed vector.
- Drives the vector on `softmax`'s `x_in`, `x_in_valid` / `softmax_ready` input handshake.
- Short rows, terminated early by `in_last`, are padded with FP16 −inf, so padded lanes contribute exp = 0 inside softmax.

Parameters:
- N, 64, lanes per vector; must be a power of 2, ≥ 2.
- W, 16, bits per lane (FP16).
- PAD_VALUE, 16'hFC00, value written to unfilled lanes (FP16 −inf).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  W  FP16 score.
- in_valid  in  1  in_data valid.
- in_last  in  1  final element of the current row; qualified by in_valid.
- in_ready  out  1  packer can accept in_data this cycle.
- x_in  out  N*W  packed vector to softmax.
- x_in_valid  out  1  x_in holds a complete vector.
- softmax_ready  in  1  softmax accepts x_in this cycle.
- lane_count  out  log2(N)+1  number of real (non-pad) lanes in the presented vector, range 1..N.

Behaviour:
- Lane mapping
  - Element k of a row (k = 0 first received) occupies x_in[(N-k)*W-1 -: W].
  - Element 0 is in the MSB lane; element N-1 is in bits [W-1:0].
- Reset (async assert, sync release)
  - State = FILL, write index idx = 0.
  - x_in = 0, x_in_valid = 0, lane_count = 0, in_ready = 1 on the first cycle after release.
- FSM: two states, FILL and OUT.
- FILL
  - in_ready = 1, x_in_valid = 0.
  - On each accept (in_valid & in_ready): lane idx ← in_data, idx ← idx+1.
  - Go to OUT after the accepted element if idx == N-1 or in_last = 1.
  - On the in_last transition, all lanes idx+1..N-1 are written with PAD_VALUE in that same edge.
  - lane_count ← idx+1 (the count of real elements).
  - idx resets to 0.
- OUT
  - in_ready = 0, x_in_valid = 1.
  - x_in and lane_count are held stable until the handshake.
  - On x_in_valid & softmax_ready: return to FILL. x_in_valid is 0 from the next cycle.
- Latency
  - The last element is accepted at edge t; x_in_valid = 1 from edge t (visible in cycle t+1).
  - Minimum handshake in cycle t+1; earliest next accept in cycle t+2.
  - Sustained throughput: N elements per N+1 cycles when softmax_ready is held 1.
- Boundary conditions
  - in_last on element N-1: normal full vector, no padding, lane_count = N.
  - in_last on element 0: lanes 1..N-1 = PAD_VALUE, lane_count = 1.
  - N elements with no in_last: the vector is emitted at N. The next element starts a new row; the row is split and no error is flagged.
  - in_valid while in OUT is ignored (in_ready = 0). The source must hold its data.
  - in_last without in_valid has no effect.
  - Lanes not yet written in FILL keep stale contents. They are invisible because x_in_valid = 0.
  - softmax_ready while in FILL is ignored.
  - rst_n low mid-row or in OUT: the partial row is discarded and all outputs return to reset values asynchronously.
- Arithmetic: no FP arithmetic; idx and lane_count are unsigned and never wrap past N.

Test Plan:
- Full row, softmax_ready = 1: stream in_data = 16'h3C00+k, k = 0..63, in_last on k = 63 → x_in_valid for exactly 1 cycle, 1 cycle after the last accept. x_in[1023:1008] = 3C00, x_in[15:0] = 3C3F, lane_count = 64.
- Short row: 5 elements 4000, 4200, 4400, 4500, 4600 with in_last on the 5th → x_in[1023:944] = those values MSB-first, remaining 59 lanes = FC00, lane_count = 5.
- Backpressure: softmax_ready = 0 for 20 cycles after x_in_valid → x_in, lane_count stable, in_ready = 0, extra in_valid ignored. Ready then pulses 1 → x_in_valid drops the next cycle and in_ready = 1.
- Back-to-back: two 64-element rows, softmax_ready tied 1, in_valid continuous → exactly one idle in_ready = 0 cycle between rows, two distinct vectors delivered in order.
- Single element with in_last: in_data = BC00 → lane 0 = BC00, lanes 1..63 = FC00, lane_count = 1.
- Reset mid-row: assert rst_n = 0 after 30 elements, release, then send a 3-element row 3800, 3A00, 3C00 with in_last → the vector contains only the new row plus 61 pad lanes, lane_count = 3.
